// File: rtl/instr_cache_pkg.sv
// Shared constants, FSM state type and address helpers for the I-cache refill engine.
package instr_cache_pkg;

  localparam int ICACHE_PADDR_WIDTH = 32;
  localparam int ICACHE_LINE_BYTES  = 64;
  localparam int ICACHE_BEAT_WIDTH  = 64;
  localparam int ICACHE_NUM_SETS    = 64;

  localparam int BEATS         = ICACHE_LINE_BYTES * 8 / ICACHE_BEAT_WIDTH;
  localparam int OFFSET_BITS   = $clog2(ICACHE_LINE_BYTES);
  localparam int SET_BITS      = $clog2(ICACHE_NUM_SETS);
  localparam int BEAT_IDX_BITS = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_DRAIN,
    ST_DONE
  } refill_state_t;

  function automatic logic [SET_BITS-1:0] set_index(input logic [ICACHE_PADDR_WIDTH-1:0] paddr);
    return paddr[OFFSET_BITS +: SET_BITS];
  endfunction

endpackage

// File: rtl/instr_cache_refill_beat_counter.sv
// Counts accepted refill beats, offsets them by the starting beat, and flags the final beat.
module refill_beat_counter #(
  parameter int BEATS  = 8,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [IDX_W-1:0] i_start_beat,
  output logic [IDX_W-1:0] o_beat,
  output logic             o_last
);

  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_accept) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Power-of-two beat count: the adder's natural wrap is the modulo.
  assign o_beat = i_start_beat + cnt_q;
  assign o_last = i_accept && (cnt_q == IDX_W'(BEATS - 1));

endmodule

// File: rtl/instr_cache_refill.sv
// I-cache line refill engine: one miss -> one line read -> per-beat data array writes.
// Define ICACHE_REFILL_CWF_EN for critical-word-first requests and wrapped beat order.
module instr_cache_refill
  import instr_cache_pkg::*;
#(
  parameter int PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH,
  parameter int NUM_SETS    = ICACHE_NUM_SETS
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_miss_valid,
  output logic                                        o_miss_ready,
  input  logic [PADDR_WIDTH-1:0]                      i_miss_paddr,
  input  logic                                        i_flush,
  output logic                                        o_mem_req_valid,
  input  logic                                        i_mem_req_ready,
  output logic [PADDR_WIDTH-1:0]                      o_mem_req_addr,
  input  logic                                        i_mem_resp_valid,
  output logic                                        o_mem_resp_ready,
  input  logic [BEAT_WIDTH-1:0]                       i_mem_resp_data,
  output logic                                        o_wr_en,
  output logic [$clog2(NUM_SETS)-1:0]                 o_wr_set,
  output logic [$clog2(LINE_BYTES*8/BEAT_WIDTH)-1:0]  o_wr_beat,
  output logic [BEAT_WIDTH-1:0]                       o_wr_data,
  output logic                                        o_refill_done,
  output logic [PADDR_WIDTH-1:0]                      o_refill_paddr
);

  localparam int LINE_BEATS = LINE_BYTES * 8 / BEAT_WIDTH;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int SET_W      = $clog2(NUM_SETS);
  localparam int BIDX_W     = $clog2(LINE_BEATS);
  localparam int BBYTE_W    = $clog2(BEAT_WIDTH / 8);
  localparam logic [PADDR_WIDTH-1:0] LINE_MASK = ~PADDR_WIDTH'(LINE_BYTES - 1);

  refill_state_t          state_q, state_d;
  logic [PADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   beat_acc, cnt_clear, cnt_last, wr_en;
  logic [BIDX_W-1:0]      start_beat, cnt_beat;

`ifdef ICACHE_REFILL_CWF_EN
  localparam logic [PADDR_WIDTH-1:0] REQ_MASK = ~PADDR_WIDTH'(BEAT_WIDTH / 8 - 1);
  assign start_beat = addr_q[OFF_W-1:BBYTE_W];
`else
  localparam logic [PADDR_WIDTH-1:0] REQ_MASK = LINE_MASK;
  assign start_beat = '0;
`endif

  assign beat_acc = i_mem_resp_valid && ((state_q == ST_RECV) || (state_q == ST_DRAIN));

  refill_beat_counter #(
    .BEATS (LINE_BEATS),
    .IDX_W (BIDX_W)
  ) u_beat_counter (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (cnt_clear),
    .i_accept     (beat_acc),
    .i_start_beat (start_beat),
    .o_beat       (cnt_beat),
    .o_last       (cnt_last)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cnt_clear        = 1'b0;
    wr_en            = 1'b0;
    o_miss_ready     = 1'b0;
    o_mem_req_valid  = 1'b0;
    o_mem_resp_ready = 1'b0;
    o_refill_done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid && !i_flush) begin
          addr_d  = i_miss_paddr;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        o_mem_req_valid = 1'b1;
        // Once the handshake completes the beats will come; a flush then has to drain them.
        if (i_mem_req_ready) begin
          cnt_clear = 1'b1;
          state_d   = i_flush ? ST_DRAIN : ST_RECV;
        end else if (i_flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        o_mem_resp_ready = 1'b1;
        if (i_flush) begin
          state_d = (i_mem_resp_valid && cnt_last) ? ST_IDLE : ST_DRAIN;
        end else if (i_mem_resp_valid) begin
          wr_en = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        o_mem_resp_ready = 1'b1;
        if (i_mem_resp_valid && cnt_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        o_refill_done = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign o_wr_en        = wr_en;
  assign o_wr_set       = wr_en ? addr_q[OFF_W +: SET_W] : '0;
  assign o_wr_beat      = wr_en ? cnt_beat : '0;
  assign o_wr_data      = wr_en ? i_mem_resp_data : '0;
  assign o_mem_req_addr = addr_q & REQ_MASK;
  assign o_refill_paddr = addr_q & LINE_MASK;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed bench for instr_cache_refill with a line-level scoreboard of expected writes and completions.
module tb_instr_cache_refill;

  localparam int NB = 8;

`ifdef ICACHE_REFILL_CWF_EN
  localparam logic [31:0] LIT_REQ   = 32'h0000_1230;
  localparam logic [2:0]  LIT_BEAT0 = 3'd6;
`else
  localparam logic [31:0] LIT_REQ   = 32'h0000_1200;
  localparam logic [2:0]  LIT_BEAT0 = 3'd0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_miss_valid = 1'b0;
  logic        o_miss_ready;
  logic [31:0] i_miss_paddr = '0;
  logic        i_flush = 1'b0;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_resp_valid = 1'b0;
  logic        o_mem_resp_ready;
  logic [63:0] i_mem_resp_data = '0;
  logic        o_wr_en;
  logic [5:0]  o_wr_set;
  logic [2:0]  o_wr_beat;
  logic [63:0] o_wr_data;
  logic        o_refill_done;
  logic [31:0] o_refill_paddr;

  instr_cache_refill dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_miss_valid     (i_miss_valid),
    .o_miss_ready     (o_miss_ready),
    .i_miss_paddr     (i_miss_paddr),
    .i_flush          (i_flush),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_resp_valid (i_mem_resp_valid),
    .o_mem_resp_ready (o_mem_resp_ready),
    .i_mem_resp_data  (i_mem_resp_data),
    .o_wr_en          (o_wr_en),
    .o_wr_set         (o_wr_set),
    .o_wr_beat        (o_wr_beat),
    .o_wr_data        (o_wr_data),
    .o_refill_done    (o_refill_done),
    .o_refill_paddr   (o_refill_paddr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  set;
    logic [2:0]  beat;
    logic [63:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_done[$];
  logic [31:0] exp_req = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] p);
    return p & ~32'h3F;
  endfunction

  function automatic logic [31:0] model_req_addr(input logic [31:0] p);
`ifdef ICACHE_REFILL_CWF_EN
    return p & ~32'h7;
`else
    return line_addr(p);
`endif
  endfunction

  function automatic int crit_beat(input logic [31:0] p);
`ifdef ICACHE_REFILL_CWF_EN
    return int'((p % 64) / 8);
`else
    return 0;
`endif
  endfunction

  function automatic wr_t model_write(input logic [31:0] p, input logic [63:0] base, input int k);
    wr_t w;
    w.set  = 6'((p / 64) % 64);
    w.beat = 3'((crit_beat(p) + k) % NB);
    w.data = base + 64'(k);
    return w;
  endfunction

  // Every cycle: each write and completion must match the next scoreboard entry.
  always @(negedge i_clk) begin
    wr_t w;
    if (!i_rst) begin
      if (i_mem_resp_valid) chk("resp_ready_when_beat", 64'(o_mem_resp_ready), 64'd1);
      if (o_mem_req_valid) chk("req_addr", 64'(o_mem_req_addr), 64'(exp_req));
      if (o_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: set %0h beat %0d data %0h, none expected", o_wr_set, o_wr_beat, o_wr_data);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_set", 64'(o_wr_set), 64'(w.set));
          chk("wr_beat", 64'(o_wr_beat), 64'(w.beat));
          chk("wr_data", o_wr_data, w.data);
        end
      end
      if (o_refill_done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: paddr %0h, none expected", o_refill_paddr);
        end else begin
          chk("done_paddr", 64'(o_refill_paddr), 64'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] p, input logic [63:0] base, input int stall, input int gap,
                      input int flush_beat, input bit flush_req, input bit flush_done, input bit use_lit);
    int nwr;
    exp_req = model_req_addr(p);
    nwr = flush_req ? 0 : ((flush_beat < 0) ? NB : flush_beat);
    for (int k = 0; k < nwr; k++) exp_wr.push_back(model_write(p, base, k));
    if (!flush_req && flush_beat < 0) exp_done.push_back(line_addr(p));

    chk("miss_ready_idle", 64'(o_miss_ready), 64'd1);
    i_miss_valid = 1'b1;
    i_miss_paddr = p;
    tick();
    i_miss_valid = 1'b0;
    chk("req_valid_t1", 64'(o_mem_req_valid), 64'd1);
    if (use_lit) chk("req_addr_lit", 64'(o_mem_req_addr), 64'(LIT_REQ));
    repeat (stall) tick();

    if (flush_req) begin
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("miss_ready_after_req_flush", 64'(o_miss_ready), 64'd1);
      chk("req_valid_after_req_flush", 64'(o_mem_req_valid), 64'd0);
    end else begin
      i_mem_req_ready = 1'b1;
      tick();
      i_mem_req_ready = 1'b0;
      for (int k = 0; k < NB; k++) begin
        repeat (gap) tick();
        i_mem_resp_valid = 1'b1;
        i_mem_resp_data  = base + 64'(k);
        i_flush = (flush_beat >= 0) && ((k == flush_beat) || (k == flush_beat + 2));
        if (use_lit && k == 0) begin
          #2;
          chk("wr_set_lit", 64'(o_wr_set), 64'h08);
          chk("wr_beat0_lit", 64'(o_wr_beat), 64'(LIT_BEAT0));
        end
        if (k == NB - 1) begin
          if (flush_beat >= 0) chk("miss_ready_while_drain", 64'(o_miss_ready), 64'd0);
          else                 chk("no_early_done", 64'(o_refill_done), 64'd0);
        end
        tick();
        i_mem_resp_valid = 1'b0;
        i_flush = 1'b0;
      end
      if (flush_beat < 0) begin
        chk("done_pulse", 64'(o_refill_done), 64'd1);
        if (use_lit) chk("done_paddr_lit", 64'(o_refill_paddr), 64'h0000_1200);
        i_flush = flush_done;
        tick();
        i_flush = 1'b0;
        chk("done_one_cycle", 64'(o_refill_done), 64'd0);
      end else begin
        chk("idle_after_drain", 64'(o_miss_ready), 64'd1);
        chk("no_done_after_flush", 64'(o_refill_done), 64'd0);
      end
    end
    chk("writes_consumed", 64'(exp_wr.size()), 64'd0);
    chk("done_consumed", 64'(exp_done.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miss_ready"}, 64'(o_miss_ready), 64'd1);
    chk({tag, "_req_valid"}, 64'(o_mem_req_valid), 64'd0);
    chk({tag, "_resp_ready"}, 64'(o_mem_resp_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
    chk({tag, "_wr_set_beat"}, 64'({o_wr_set, o_wr_beat}), 64'd0);
    chk({tag, "_wr_data"}, o_wr_data, 64'd0);
    chk({tag, "_done"}, 64'(o_refill_done), 64'd0);
    chk({tag, "_addrs"}, {o_mem_req_addr, o_refill_paddr}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa, pb;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_rst = 1'b0;
    tick();

    fill(32'h0000_1234, 64'd0, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    fill(32'h0000_8A40, 64'h100, 3, 1, -1, 1'b0, 1'b1, 1'b0);
    fill(32'h0000_4444, 64'd0, 2, 0, -1, 1'b1, 1'b0, 1'b0);
    fill(32'h0000_7F98, 64'hA0, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    fill(32'h0001_0008, 64'hC0, 0, 2, -1, 1'b0, 1'b0, 1'b0);

    // Back-to-back misses with valid held high, then async reset in the middle of the second fill.
    pa = 32'h0000_2040;
    pb = 32'h0000_3FC8;
    for (int k = 0; k < NB; k++) exp_wr.push_back(model_write(pa, 64'h200, k));
    exp_done.push_back(line_addr(pa));
    exp_req = model_req_addr(pa);
    i_miss_valid = 1'b1;
    i_miss_paddr = pa;
    tick();
    i_miss_paddr = pb;
    chk("b2b_req_valid_a", 64'(o_mem_req_valid), 64'd1);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = 64'h200 + 64'(k);
      tick();
    end
    i_mem_resp_valid = 1'b0;
    chk("b2b_done_a", 64'(o_refill_done), 64'd1);
    chk("b2b_not_ready_in_done", 64'(o_miss_ready), 64'd0);
    exp_req = model_req_addr(pb);
    tick();
    chk("b2b_ready_after_done", 64'(o_miss_ready), 64'd1);
    tick();
    i_miss_valid = 1'b0;
    chk("b2b_req_valid_b", 64'(o_mem_req_valid), 64'd1);
    for (int k = 0; k < 2; k++) exp_wr.push_back(model_write(pb, 64'h300, k));
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = 64'h300 + 64'(k);
      tick();
    end
    i_mem_resp_valid = 1'b0;
    chk("recv_before_reset", 64'(o_mem_resp_ready), 64'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    i_rst = 1'b0;
    tick();
    chk("b2b_writes_consumed", 64'(exp_wr.size()), 64'd0);
    chk("b2b_done_consumed", 64'(exp_done.size()), 64'd0);

    fill(32'h0000_1234, 64'd0, 0, 0, -1, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_cache_refill.md
Name: instr_cache_refill

Overview:
- Fill engine for the instruction cache data array: the writer side of the array that the fetch stage reads.
- Accepts one line-miss request from fetch and issues a line read on the memory port.
- Collects the returned beats and writes each one into the data array through a beat-granular write port.
- Pulses completion so fetch can replay; a flush aborts the fill and drains the remaining beats without writing them.

Parameters:
- PADDR_WIDTH, 32, physical address width (matches `PADDR_WIDTH).
- LINE_BYTES, 64, cache line size in bytes (power of 2).
- BEAT_WIDTH, 64, memory response data width in bits.
- NUM_SETS, 64, number of sets in the data array (power of 2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_miss_valid  in  1  miss request valid
- o_miss_ready  out  1  engine can accept a miss (state IDLE)
- i_miss_paddr  in  PADDR_WIDTH  missing fetch address
- i_flush  in  1  abort the current fill
- o_mem_req_valid  out  1  line read request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  PADDR_WIDTH  request address
- i_mem_resp_valid  in  1  response beat valid
- o_mem_resp_ready  out  1  engine accepts beat
- i_mem_resp_data  in  BEAT_WIDTH  beat payload
- o_wr_en  out  1  data array write strobe
- o_wr_set  out  log2(NUM_SETS)  set index
- o_wr_beat  out  log2(BEATS)  beat index within line
- o_wr_data  out  BEAT_WIDTH  write data
- o_refill_done  out  1  one-cycle completion pulse
- o_refill_paddr  out  PADDR_WIDTH  line-aligned address of the completed line

Behaviour:
- Derived constants: BEATS = LINE_BYTES*8/BEAT_WIDTH; OFFSET_BITS = log2(LINE_BYTES).
- Set index = paddr[OFFSET_BITS +: log2(NUM_SETS)].
- Reset values: state IDLE; all outputs 0 except o_miss_ready = 1; beat counter 0; latched address 0.

State machine (IDLE, REQ, RECV, DRAIN, DONE):
- IDLE: o_miss_ready = 1.
  - i_miss_valid & !i_flush: latch paddr, go to REQ next cycle.
  - Flush in the same cycle as a miss: the miss is dropped.
- REQ: o_mem_req_valid = 1; address stable until accepted.
  - i_mem_req_ready: go to RECV, counter = 0.
  - i_flush before acceptance: go to IDLE with no memory transaction.
- RECV: o_mem_resp_ready = 1.
  - Each accepted beat drives o_wr_en, o_wr_set, o_wr_beat and o_wr_data combinationally in the same cycle.
  - Counter increments modulo BEATS.
  - On the BEATS-th beat, go to DONE.
  - i_flush: go to DRAIN; the beat accepted in the flush cycle is not written (o_wr_en = 0).
- DRAIN: o_mem_resp_ready = 1, o_wr_en = 0. Consume the remaining beats, then go to IDLE with no done pulse.
  - Flush while already in DRAIN has no effect.
- DONE: o_refill_done = 1 for exactly one cycle; o_refill_paddr = latched address with offset bits zeroed. Then go to IDLE.
  - Flush in DONE is ignored; the line is already complete.

Other rules:
- Latency: miss accepted at cycle t gives o_mem_req_valid at t+1. With zero memory stall, done arrives at the last beat cycle + 1.
- Response beats never arrive outside RECV/DRAIN. This is a bench assertion, not handled by the block.
- Asynchronous reset mid-fill returns to IDLE immediately. Outstanding beats are the memory side's responsibility.

Optional Feature:
- Macro ICACHE_REFILL_CWF_EN (critical word first).
- Defined:
  - o_mem_req_addr = miss address aligned to BEAT_WIDTH/8.
  - Beats return starting at the critical beat and wrap.
  - o_wr_beat = (critical_beat + counter) mod BEATS.
  - Completion is still after BEATS beats.
- Undefined:
  - o_mem_req_addr is line-aligned.
  - o_wr_beat = counter.

Decomposition:
- Package instr_cache_pkg holds:
  - derived constants BEATS, OFFSET_BITS, SET_BITS and BEAT_IDX_BITS;
  - the refill_state_t enum;
  - a set-index extraction function.
- One natural sub-module, refill_beat_counter: counts accepted beats, applies the CWF start offset, and flags the last beat.

Test Plan:
- Basic fill, miss paddr 0x0000_1234: req addr 0x0000_1200; 8 beats of data 0..7 give writes set 0x08, beats 0..7; one done pulse with paddr 0x0000_1200.
- Memory stalls (req_ready low 3 cycles, resp_valid gaps): request address held stable; exactly 8 writes; done only after the 8th beat.
- Flush in REQ before req_ready: returns to IDLE; no request accepted; no writes; no done pulse; o_miss_ready = 1 next cycle.
- Flush after beat 3 in RECV: beats 0..2 written; remaining beats consumed with o_wr_en = 0; no done pulse; next miss accepted only after the 8th beat.
- With ICACHE_REFILL_CWF_EN, miss paddr 0x0000_1234: req addr 0x0000_1230; o_wr_beat sequence 6,7,0,1,2,3,4,5; done paddr 0x0000_1200.
- Back-to-back misses with i_miss_valid held high: second miss accepted only in the cycle after done; i_rst pulse mid-RECV sends all outputs to reset values asynchronously.
